// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU ALU sequencing controller:
// opcodes, controller states and instruction field offsets.
package mcpu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  // Instruction layout is {opcode, rd, rs1, rs2}, with rs2 in the LSBs.
  localparam int unsigned RS2_LSB = 0;

  function automatic int unsigned rs1_lsb(input int unsigned reg_addr);
    return reg_addr;
  endfunction

  function automatic int unsigned rd_lsb(input int unsigned reg_addr);
    return 2 * reg_addr;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned reg_addr);
    return 3 * reg_addr;
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// Register file: two combinational read ports and a shared write path in which
// the controller writeback overrides a host write to the same index.
module mcpu_regfile #(
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned REG_ADDR  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_ADDR-1:0]  rd_addr_a,
  output logic [WORD_SIZE-1:0] rd_data_a,
  input  logic [REG_ADDR-1:0]  rd_addr_b,
  output logic [WORD_SIZE-1:0] rd_data_b,
  input  logic                 host_we,
  input  logic [REG_ADDR-1:0]  host_addr,
  input  logic [WORD_SIZE-1:0] host_data,
  input  logic                 wb_we,
  input  logic [REG_ADDR-1:0]  wb_addr,
  input  logic [WORD_SIZE-1:0] wb_data
);

  localparam int unsigned DEPTH = 1 << REG_ADDR;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] mem_d [DEPTH];

  // Reads see the pre-edge contents, giving read-before-write behaviour.
  assign rd_data_a = mem_q[rd_addr_a];
  assign rd_data_b = mem_q[rd_addr_b];

  always_comb begin
    mem_d = mem_q;
    if (host_we) mem_d[host_addr] = host_data;
    // Applied last so the writeback wins on an index collision.
    if (wb_we) mem_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/mcpu_alu_ctrl.sv
// Issues one instruction at a time to the external MCPU_Alu and returns its result.
// Optional result checker enabled by defining MCPU_ALU_CTRL_SELFCHECK_EN.
module mcpu_alu_ctrl
  import mcpu_pkg::*;
#(
  parameter int unsigned CMD_SIZE  = 2,
  parameter int unsigned WORD_SIZE = 4,
  parameter int unsigned REG_ADDR  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [CMD_SIZE+3*REG_ADDR-1:0] instr,
  input  logic                         wr_en,
  input  logic [REG_ADDR-1:0]          wr_addr,
  input  logic [WORD_SIZE-1:0]         wr_data,
  output logic [CMD_SIZE-1:0]          alu_opcode,
  output logic [WORD_SIZE-1:0]         alu_r1,
  output logic [WORD_SIZE-1:0]         alu_r2,
  input  logic [WORD_SIZE-1:0]         alu_out,
  input  logic                         alu_overflow,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WORD_SIZE-1:0]         rsp_data,
  output logic                         rsp_overflow,
  output logic                         err
);

  localparam int unsigned RS1_LSB = rs1_lsb(REG_ADDR);
  localparam int unsigned RD_LSB  = rd_lsb(REG_ADDR);
  localparam int unsigned OP_LSB  = op_lsb(REG_ADDR);

  state_e               state_q, state_d;
  logic [CMD_SIZE-1:0]  op_q, op_d;
  logic [WORD_SIZE-1:0] r1_q, r1_d;
  logic [WORD_SIZE-1:0] r2_q, r2_d;
  logic [REG_ADDR-1:0]  rd_q, rd_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_ovf_q, rsp_ovf_d;

  logic [REG_ADDR-1:0]  rs1_idx, rs2_idx;
  logic [WORD_SIZE-1:0] rs1_val, rs2_val;
  logic                 wb_we;

  assign rs1_idx = instr[RS1_LSB +: REG_ADDR];
  assign rs2_idx = instr[RS2_LSB +: REG_ADDR];

  mcpu_regfile #(
    .WORD_SIZE(WORD_SIZE),
    .REG_ADDR (REG_ADDR)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .rd_addr_a(rs1_idx),
    .rd_data_a(rs1_val),
    .rd_addr_b(rs2_idx),
    .rd_data_b(rs2_val),
    .host_we  (wr_en),
    .host_addr(wr_addr),
    .host_data(wr_data),
    .wb_we    (wb_we),
    .wb_addr  (rd_q),
    .wb_data  (alu_out)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    rd_d        = rd_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    wb_we       = 1'b0;
    instr_ready = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          op_d    = instr[OP_LSB +: CMD_SIZE];
          r1_d    = rs1_val;
          r2_d    = rs2_val;
          rd_d    = instr[RD_LSB +: REG_ADDR];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        wb_we      = 1'b1;
        rsp_data_d = alu_out;
        rsp_ovf_d  = alu_overflow;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      r1_q       <= '0;
      r2_q       <= '0;
      rd_q       <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      rd_q       <= rd_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
    end
  end

  assign alu_opcode   = op_q;
  assign alu_r1       = r1_q;
  assign alu_r2       = r2_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_overflow = rsp_ovf_q;

`ifdef MCPU_ALU_CTRL_SELFCHECK_EN
  logic [WORD_SIZE:0]   exp_sum;
  logic [WORD_SIZE-1:0] exp_res;
  logic                 exp_ovf;
  logic                 err_q, err_d;

  always_comb begin
    exp_sum = {1'b0, r1_q} + {1'b0, r2_q};
    exp_res = '0;
    exp_ovf = 1'b0;
    case (op_q)
      OP_AND:  exp_res = r1_q & r2_q;
      OP_OR:   exp_res = r1_q | r2_q;
      OP_XOR:  exp_res = r1_q ^ r2_q;
      default: {exp_ovf, exp_res} = exp_sum;
    endcase
    err_d = err_q;
    if (state_q == ST_EXEC && (alu_out != exp_res || alu_overflow != exp_ovf)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_alu_ctrl.sv
// Self-checking bench for mcpu_alu_ctrl with a behavioural ALU stub and a result scoreboard.
module tb_mcpu_alu_ctrl;

  localparam int CW = 2;
  localparam int WW = 4;
  localparam int RA = 2;

  logic              clk;
  logic              reset;
  logic              instr_valid;
  logic              instr_ready;
  logic [CW+3*RA-1:0] instr;
  logic              wr_en;
  logic [RA-1:0]     wr_addr;
  logic [WW-1:0]     wr_data;
  logic [CW-1:0]     alu_opcode;
  logic [WW-1:0]     alu_r1;
  logic [WW-1:0]     alu_r2;
  logic [WW-1:0]     alu_out;
  logic              alu_overflow;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WW-1:0]     rsp_data;
  logic              rsp_overflow;
  logic              err;
  logic              corrupt_add;

  mcpu_alu_ctrl #(
    .CMD_SIZE (CW),
    .WORD_SIZE(WW),
    .REG_ADDR (RA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .alu_opcode  (alu_opcode),
    .alu_r1      (alu_r1),
    .alu_r2      (alu_r2),
    .alu_out     (alu_out),
    .alu_overflow(alu_overflow),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_overflow(rsp_overflow),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub; corrupt_add makes ADD return result+1.
  always_comb begin
    case (alu_opcode)
      2'b00:   {alu_overflow, alu_out} = {1'b0, alu_r1 & alu_r2};
      2'b01:   {alu_overflow, alu_out} = {1'b0, alu_r1 | alu_r2};
      2'b10:   {alu_overflow, alu_out} = {1'b0, alu_r1 ^ alu_r2};
      default: {alu_overflow, alu_out} = {1'b0, alu_r1} + {1'b0, alu_r2} + {4'd0, corrupt_add};
    endcase
  end

  int total = 0;
  int bad   = 0;

  logic [WW-1:0] shadow [4];
  logic [WW:0]   sb_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW:0] ref_op(input logic [1:0] op, input logic [WW-1:0] a,
                                         input logic [WW-1:0] b);
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  task automatic host_write(input logic [RA-1:0] a, input logic [WW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    shadow[a] = d;
  endtask

  // mode: 0 normal, 1 host write to rd during EXEC, 2 reset during EXEC.
  task automatic issue(input logic [1:0] op, input logic [RA-1:0] rd, input logic [RA-1:0] rs1,
                       input logic [RA-1:0] rs2, input int hold, input int mode);
    logic [WW:0] e;
    logic [WW:0] got;
    bit          ok;
    e = ref_op(op, shadow[rs1], shadow[rs2]);
    if (corrupt_add && op == 2'b11) e = e + 5'd1;
    sb_q.push_back(e);
    @(negedge clk);
    instr = {op, rd, rs1, rs2};
    instr_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      check_eq("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      sb_q.delete();
      return;
    end
    @(negedge clk);
    if (hold == 0) instr_valid = 1'b0;
    check_eq("exec_rsp_valid", rsp_valid, 0);
    check_eq("exec_instr_ready", instr_ready, 0);
    check_eq("alu_opcode", alu_opcode, op);
    check_eq("alu_r1", alu_r1, shadow[rs1]);
    check_eq("alu_r2", alu_r2, shadow[rs2]);
    if (mode == 1) begin
      wr_en = 1'b1; wr_addr = rd; wr_data = '1;
    end
    if (mode == 2) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      for (int k = 0; k < 4; k++) shadow[k] = '0;
      check_eq("rst_instr_ready", instr_ready, 1);
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_alu_opcode", alu_opcode, 0);
      check_eq("rst_alu_r1", alu_r1, 0);
      check_eq("rst_alu_r2", alu_r2, 0);
      check_eq("rst_rsp_data", rsp_data, 0);
      check_eq("rst_rsp_ovf", rsp_overflow, 0);
      check_eq("rst_err", err, 0);
      @(negedge clk);
      check_eq("rst_no_rsp", rsp_valid, 0);
      return;
    end
    @(negedge clk);
    wr_en = 1'b0;
    shadow[rd] = e[WW-1:0];
    check_eq("done_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_rsp_valid", rsp_valid, 1);
      check_eq("hold_instr_ready", instr_ready, 0);
      check_eq("hold_rsp_data", rsp_data, e[WW-1:0]);
      @(negedge clk);
    end
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      check_eq("rsp_data", rsp_data, got[WW-1:0]);
      check_eq("rsp_overflow", rsp_overflow, got[WW]);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    instr_valid = 1'b0;
    check_eq("post_rsp_valid", rsp_valid, 0);
    check_eq("post_instr_ready", instr_ready, 1);
    if (hold > 0) begin
      @(negedge clk);
      check_eq("no_second_accept", instr_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rsp_ready = 1'b0; corrupt_add = 1'b0;
    for (int k = 0; k < 4; k++) shadow[k] = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_rsp_valid", rsp_valid, 0);
    check_eq("reset_rsp_data", rsp_data, 0);
    check_eq("reset_alu_r1", alu_r1, 0);
    check_eq("reset_err", err, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_instr_ready", instr_ready, 1);

    host_write(2'd1, 4'd4);
    host_write(2'd2, 4'd9);
    issue(2'b11, 2'd3, 2'd1, 2'd2, 0, 0);   // 4+9 = 13
    issue(2'b01, 2'd3, 2'd3, 2'd3, 0, 0);   // r3 readback

    host_write(2'd1, 4'd8);
    issue(2'b11, 2'd0, 2'd1, 2'd2, 0, 0);   // 8+9 -> 1 with carry

    host_write(2'd1, 4'hC);
    host_write(2'd2, 4'hA);
    issue(2'b00, 2'd3, 2'd1, 2'd2, 0, 0);   // 8
    issue(2'b01, 2'd0, 2'd1, 2'd2, 0, 0);   // E
    issue(2'b10, 2'd3, 2'd1, 2'd2, 5, 0);   // 6, response held

    issue(2'b11, 2'd3, 2'd1, 2'd2, 0, 1);   // writeback beats host write
    issue(2'b01, 2'd0, 2'd3, 2'd3, 0, 0);

    issue(2'b11, 2'd3, 2'd1, 2'd2, 0, 2);   // reset mid-operation
    for (int k = 0; k < 4; k++) issue(2'b01, 2'(k), 2'(k), 2'(k), 0, 0);

`ifdef MCPU_ALU_CTRL_SELFCHECK_EN
    host_write(2'd1, 4'd4);
    host_write(2'd2, 4'd9);
    corrupt_add = 1'b1;
    issue(2'b11, 2'd3, 2'd1, 2'd2, 0, 0);
    check_eq("err_set", err, 1);
    repeat (3) @(negedge clk);
    check_eq("err_sticky", err, 1);
    corrupt_add = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("err_cleared", err, 0);
`else
    check_eq("err_tied_low", err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
